// File: rtl/irq_capture_pkg.sv
// Shared constants, FSM state type and priority selection for irq_capture_4ch.
package irq_capture_pkg;

    localparam int CH_NUM = 4;
    localparam int CODE_W = 2;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_e;

    // Highest set index wins (3 > 2 > 1 > 0); all-zero input maps to 0, callers gate on non-zero.
    function automatic logic [CODE_W-1:0] prio_sel(input logic [CH_NUM-1:0] v);
        logic [CODE_W-1:0] r;
        if (v[3])      r = 2'd3;
        else if (v[2]) r = 2'd2;
        else if (v[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser per bit followed by a history flop; emits a one-cycle rising-edge pulse.
module sync_edge_detect #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             hist_q, hist_d;

    // Shift the asynchronous input down the chain; history holds the previous synchronised value.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_q[STAGES-1];
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_capture_4ch.sv
// Four-channel request capture: synchronise, edge-detect, hold sticky pending bits and
// deliver one event at a time, highest channel first, flagging lost events per channel.
//
// Handshake: out_valid/out_code describe the slot. A transfer happens on a rising clk edge
// where out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0 the slot is held
// stable. out_valid never drops without a transfer (except on reset).
module irq_capture_4ch
    import irq_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic [3:0] pending,
    output logic [3:0] overflow,
    input  logic [3:0] ovf_clr,
    output logic       dbg_state
);

    state_e      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  overflow_q, overflow_d;
    logic [1:0]  code_q, code_d;

    logic [3:0]  rise;
    logic [3:0]  cap;
    logic [1:0]  sel;
    logic        any_pend;
    logic        accept;
    logic        load;
    logic [3:0]  clr_vec;

    sync_edge_detect #(
        .WIDTH  (CH_NUM),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (req_in),
        .rise  (rise)
    );

    assign cap      = rise & mask;
    assign sel      = prio_sel(pending_q);
    assign any_pend = (pending_q != 4'b0000);
    assign accept   = (state_q == S_PRESENT) && out_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: fill an empty slot, empty it when accepted with nothing left pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_pend)            state_d = S_PRESENT;
            S_PRESENT: if (accept && !any_pend) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs: slot load, pending/overflow update and code capture.
    always_comb begin
        load       = any_pend && ((state_q == S_IDLE) || accept);
        clr_vec    = load ? (4'b0001 << sel) : 4'b0000;
        // A fresh capture beats the load clear, so a same-cycle event on sel stays pending.
        pending_d  = (pending_q & ~clr_vec) | cap;
        // An event is lost only if it hits a bit that remains pending after this cycle's load.
        overflow_d = (overflow_q & ~ovf_clr) | (cap & pending_q & ~clr_vec);
        code_d     = load ? sel : code_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
            code_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            code_q     <= code_d;
        end
    end

    assign out_valid = (state_q == S_PRESENT);
    assign out_code  = code_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_capture_4ch.sv
// Directed testbench for irq_capture_4ch with hand-computed expectations.
module tb_irq_capture_4ch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] ovf_clr;
    logic       dbg_state;

    int passed;
    int total;

    irq_capture_4ch #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 4'h0; mask = 4'hF; out_ready = 1'b1; ovf_clr = 4'h0;
        idle_wait(3);
        total++;
        if ({out_valid, out_code, pending, overflow, dbg_state} !== 12'h000)
            $display("FAIL reset_state: got v=%b c=%h p=%h o=%h s=%b, want all 0",
                     out_valid, out_code, pending, overflow, dbg_state);
        else passed++;
        rst_n = 1'b1;
        idle_wait(4);
        total++;
        if ({out_valid, pending} !== 5'b0)
            $display("FAIL reset_quiet: got v=%b p=%h, want 0", out_valid, pending);
        else passed++;
    endtask

    task automatic test_single();
        req_in = 4'b0100;
        idle_wait(3);
        total++;
        if (pending !== 4'b0100 || out_valid !== 1'b0)
            $display("FAIL single_pend: got p=%h v=%b, want p=4 v=0", pending, out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd2 || pending !== 4'h0)
            $display("FAIL single_out: got v=%b c=%0d p=%h, want v=1 c=2 p=0", out_valid, out_code, pending);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_code !== 2'd2)
            $display("FAIL single_done: got v=%b c=%0d, want v=0 c=2", out_valid, out_code);
        else passed++;
        idle_wait(4);
        total++;
        if (out_valid !== 1'b0 || pending !== 4'h0)
            $display("FAIL single_level: got v=%b p=%h, want 0", out_valid, pending);
        else passed++;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    task automatic test_priority();
        logic [1:0] exp_codes [3];
        logic [3:0] exp_pend  [3];
        exp_codes[0] = 2'd3; exp_codes[1] = 2'd1; exp_codes[2] = 2'd0;
        exp_pend[0]  = 4'b0011; exp_pend[1] = 4'b0001; exp_pend[2] = 4'b0000;
        req_in = 4'b1011;
        idle_wait(3);
        total++;
        if (pending !== 4'b1011)
            $display("FAIL prio_pend: got %b, want 1011", pending);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_code !== exp_codes[i] || pending !== exp_pend[i])
                $display("FAIL prio_b2b[%0d]: got v=%b c=%0d p=%b, want v=1 c=%0d p=%b",
                         i, out_valid, out_code, pending, exp_codes[i], exp_pend[i]);
            else passed++;
        end
        tick();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL prio_end: got v=%b, want 0", out_valid);
        else passed++;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_in = 4'b0100;
        idle_wait(4);
        req_in = 4'b1100;
        idle_wait(3);
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd2 || pending !== 4'b1000)
            $display("FAIL bp_hold: got v=%b c=%0d p=%b, want v=1 c=2 p=1000", out_valid, out_code, pending);
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd3 || pending !== 4'h0)
            $display("FAIL bp_next: got v=%b c=%0d p=%b, want v=1 c=3 p=0", out_valid, out_code, pending);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd3)
            $display("FAIL bp_stable: got v=%b c=%0d, want v=1 c=3", out_valid, out_code);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL bp_drain: got v=%b, want 0", out_valid);
        else passed++;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        req_in = 4'b0001;
        idle_wait(4);
        for (int p = 0; p < 2; p++) begin
            req_in = 4'b0011;
            idle_wait(3);
            req_in = 4'b0001;
            idle_wait(3);
        end
        total++;
        if (overflow !== 4'b0010 || pending !== 4'b0010 || out_code !== 2'd0)
            $display("FAIL ovf_set: got o=%b p=%b c=%0d, want o=0010 p=0010 c=0", overflow, pending, out_code);
        else passed++;
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        total++;
        if (overflow !== 4'b0000)
            $display("FAIL ovf_clr: got %b, want 0000", overflow);
        else passed++;
        // Capture lands on the third edge after the raise; clear coincides with it.
        req_in = 4'b0011;
        idle_wait(2);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        total++;
        if (overflow !== 4'b0010)
            $display("FAIL ovf_set_wins: got %b, want 0010", overflow);
        else passed++;
        req_in = 4'b0001;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd1 || pending !== 4'h0)
            $display("FAIL ovf_drain: got v=%b c=%0d p=%b, want v=1 c=1 p=0", out_valid, out_code, pending);
        else passed++;
        ovf_clr = 4'hF;
        tick();
        ovf_clr = 4'h0;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    task automatic test_mask();
        out_ready = 1'b1;
        mask = 4'b1110;
        req_in = 4'b0001;
        idle_wait(3);
        req_in = 4'b0000;
        idle_wait(3);
        total++;
        if (out_valid !== 1'b0 || pending !== 4'h0)
            $display("FAIL mask_drop: got v=%b p=%b, want 0", out_valid, pending);
        else passed++;
        mask = 4'hF;
        out_ready = 1'b0;
        req_in = 4'b1000;
        idle_wait(4);
        req_in = 4'b1100;
        idle_wait(3);
        mask = 4'b1011;
        tick();
        total++;
        if (pending !== 4'b0100 || out_code !== 2'd3)
            $display("FAIL mask_keep: got p=%b c=%0d, want p=0100 c=3", pending, out_code);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd2)
            $display("FAIL mask_deliver: got v=%b c=%0d, want v=1 c=2", out_valid, out_code);
        else passed++;
        tick();
        mask = 4'hF;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_in = 4'b1101;
        idle_wait(4);
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd3 || pending !== 4'b0101)
            $display("FAIL rst_pre: got v=%b c=%0d p=%b, want v=1 c=3 p=0101", out_valid, out_code, pending);
        else passed++;
        #2;
        rst_n = 1'b0;
        req_in = 4'b0010;
        #1;
        total++;
        if ({out_valid, out_code, pending, overflow} !== 11'h000)
            $display("FAIL rst_async: got v=%b c=%0d p=%b o=%b, want 0", out_valid, out_code, pending, overflow);
        else passed++;
        idle_wait(2);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (pending !== 4'b0010 || out_valid !== 1'b0)
            $display("FAIL rst_fresh_pend: got p=%b v=%b, want p=0010 v=0", pending, out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 2'd1)
            $display("FAIL rst_fresh_out: got v=%b c=%0d, want v=1 c=1", out_valid, out_code);
        else passed++;
        idle_wait(5);
        total++;
        if (out_valid !== 1'b0 || pending !== 4'h0)
            $display("FAIL rst_once: got v=%b p=%b, want 0", out_valid, pending);
        else passed++;
        req_in = 4'h0;
        idle_wait(4);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_overflow();
        test_mask();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/irq_capture_4ch.md
Name: irq_capture_4ch

Overview:
Upstream request-capture stage for the 4-to-2 priority encoder path. It takes four asynchronous request lines, synchronises them and detects rising edges, then holds each event as a sticky pending bit. It presents one event at a time as a 2-bit code with a valid/ready handshake, highest index first, matching the encoder's priority order. Each event is delivered exactly once, and lost events are flagged per channel.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per request bit (legal range 2..4)

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, release is synchronous to clk
req_in  input  4  asynchronous request lines; a rising edge on bit i is one event on channel i
mask  input  4  synchronous capture enable; bit i=1 allows channel i edges to be captured
out_valid  output  1  slot holds an undelivered event
out_ready  input  1  consumer accepts the slot when out_valid and out_ready are both 1
out_code  output  2  channel index of the event in the slot
pending  output  4  registered pending bits, excluding the slot contents
overflow  output  4  sticky per-channel lost-event flags
ovf_clr  input  4  single-cycle per-bit clear of overflow

Behaviour:
- Reset values: out_valid=0, out_code=2'b00, pending=0, overflow=0, synchroniser and edge-history flops=0, state=S_IDLE.
- Synchroniser: a chain of SYNC_STAGES flops per bit, followed by a history flop. edge[i] = sync_out[i] & ~hist[i].
- A req_in bit already high at reset release produces one edge. This is intended.
- Capture: on edge[i] & mask[i], set pending[i]. Masked edges are dropped and never stored.
- Mask changes do not affect bits that are already pending. Those bits are still delivered.
- Overflow: edge[i] & mask[i] while pending[i]=1 sets overflow[i]. This counts as one event lost.
- An edge on the channel currently held in the slot is not an overflow. It sets pending[i] normally.
- ovf_clr[i] clears overflow[i]. If set and clear occur in the same cycle, set wins.
- Selection: sel = highest index i with pending[i]=1 (3 > 2 > 1 > 0).
- FSM, two states:
  - S_IDLE: out_valid=0. If pending != 0, load out_code=sel, clear pending[sel], set out_valid=1, go to S_PRESENT.
  - S_PRESENT: out_valid=1. out_code is held stable while out_ready=0.
  - S_PRESENT on accept with pending != 0: load the next sel in the same cycle (back-to-back delivery, 1 event/cycle) and stay in S_PRESENT.
  - S_PRESENT on accept with pending = 0: out_valid=0, go to S_IDLE. out_code keeps its last value.
- Simultaneous load and capture on the same channel: set wins, so pending[sel] stays 1. The new event is delivered later.
- Latency, measured with an empty pending register and S_IDLE:
  - First rising edge sampling req_in[i]=1 is edge 1.
  - pending[i]=1 after edge SYNC_STAGES+1.
  - out_valid=1 and out_code=i after edge SYNC_STAGES+2 (4 with the default).
- A req_in pulse must stay high and low for at least 2 clk cycles each to be guaranteed a capture. Shorter pulses may be missed.
- Reset mid-operation: an undelivered slot, pending bits and overflow flags are all discarded. After release, lines that are still high each generate one fresh edge.

Decomposition:
- Shared package irq_capture_pkg:
  - constants CH_NUM=4, CODE_W=2
  - state enum {S_IDLE, S_PRESENT}
  - pure function prio_sel(logic [3:0]) returning the 2-bit highest-set index; returns 0 for all-zero input, but the caller gates on non-zero
- Sub-module sync_edge_detect:
  - parameters WIDTH and STAGES
  - contains the synchroniser chain, the history flop and the rising-edge output
  - same clk/rst_n convention as the parent
  - instantiated once with WIDTH=4

Test Plan:
- Single event: hold out_ready=1, mask=4'hF, raise req_in[2] and keep it high → out_valid=1 with out_code=2'b10 for exactly 1 cycle, 4 cycles after the first sampling edge, then pending=0. No further events while req_in stays high.
- Priority and back-to-back: raise req_in[0], req_in[1] and req_in[3] in the same cycle, out_ready=1 → codes 3, 1, 0 on three consecutive cycles, then out_valid=0.
- Backpressure: hold out_ready=0 with code 2 in the slot, then raise req_in[3] → out_code stays 2'b10 while pending=4'b1000. Raise out_ready for 1 cycle → the next cycle shows out_code=2'b11.
- Overflow: with out_ready=0 and the slot occupied by channel 0, pulse req_in[1] twice (each pulse 3 cycles high, 3 cycles low) → overflow=4'b0010 and pending[1]=1. Pulse ovf_clr[1] → overflow=0. If ovf_clr coincides with a new overflow edge → overflow stays set.
- Masking: set mask=4'b1110 and pulse req_in[0] → no event. Set pending[2]=1, then drop mask[2] → code 2 is still delivered.
- Reset mid-operation: assert rst_n=0 asynchronously between clk edges while out_valid=1 and pending=4'b0101 → all outputs 0 immediately. Release with req_in[1] held high → exactly one event, code 1, after 4 cycles.
